// File: rtl/mips_data_dump_sequencer.sv
// mips_data_dump_sequencer
// Owns the data-memory port between the CPU and the data RAM. While the CPU runs,
// its data-port signals pass straight through to the RAM. Once the CPU drops
// `active`, the block takes over the port. It reads WORD_COUNT words starting at
// BASE_ADDR and streams them out on a valid/ready port.
module mips_data_dump_sequencer #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0480,
   parameter int          WORD_COUNT = 30,
   parameter int          IDX_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              active,
   input  logic [31:0]       cpu_data_address,
   input  logic              cpu_data_write,
   input  logic              cpu_data_read,
   input  logic [31:0]       cpu_data_writedata,
   output logic [31:0]       cpu_data_readdata,
   output logic [31:0]       data_address,
   output logic              data_write,
   output logic              data_read,
   output logic [31:0]       data_writedata,
   input  logic [31:0]       data_readdata,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [31:0]       dump_data,
   output logic [IDX_W-1:0]  dump_index,
   output logic              busy,
   output logic              done,
   output logic              conflict
);

   typedef enum logic [2:0] {
      WAIT_START,
      RUN,
      READ,
      PRESENT,
      DONE
   } state_t;

   // The dump base address is always word aligned; the low two bits are ignored.
   localparam logic [31:0]      BASE_ALIGNED = {BASE_ADDR[31:2], 2'b00};
   // This value is only meaningful when WORD_COUNT > 0.
   // With WORD_COUNT == 0, RUN goes straight to DONE and this value is never compared.
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(WORD_COUNT - 1);

   state_t            state_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [31:0]       dump_data_reg;
   logic              dump_valid_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              conflict_reg;
   logic [31:0]       dump_address;

   // Address arithmetic wraps modulo 2**32.
   // A base near the top of memory therefore rolls over into low addresses.
   assign dump_address = BASE_ALIGNED + (32'(idx_reg) << 2);

   assign cpu_data_readdata = data_readdata;
   assign dump_valid        = dump_valid_reg;
   assign dump_data         = dump_data_reg;
   assign dump_index        = idx_reg;
   assign busy              = busy_reg;
   assign done              = done_reg;
   assign conflict          = conflict_reg;

   // RAM port ownership: pass-through unless the sequencer is mid-dump.
   always_comb begin
      data_address   = cpu_data_address;
      data_write     = cpu_data_write;
      data_read      = cpu_data_read;
      data_writedata = cpu_data_writedata;
      if (busy_reg) begin
         data_address   = dump_address;
         data_write     = 1'b0;
         data_read      = (state_reg == READ);
         data_writedata = 32'h0;
      end
   end

   // Sequencer FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= WAIT_START;
         idx_reg        <= '0;
         dump_data_reg  <= 32'h0;
         dump_valid_reg <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         conflict_reg   <= 1'b0;
      end else begin
         // Any CPU strobe while the port is taken is blocked and flagged.
         if (busy_reg && (cpu_data_write || cpu_data_read))
            conflict_reg <= 1'b1;

         case (state_reg)
            WAIT_START: begin
               if (active)
                  state_reg <= RUN;
            end
            RUN: begin
               if (!active) begin
                  if (WORD_COUNT == 0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= READ;
                     busy_reg  <= 1'b1;
                  end
               end
            end
            READ: begin
               dump_data_reg  <= data_readdata;
               dump_valid_reg <= 1'b1;
               state_reg      <= PRESENT;
            end
            PRESENT: begin
               if (dump_ready) begin
                  dump_valid_reg <= 1'b0;
                  if (idx_reg == LAST_IDX) begin
                     state_reg <= DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     idx_reg   <= idx_reg + 1'b1;
                     state_reg <= READ;
                  end
               end
            end
            DONE: begin
               state_reg <= DONE;
            end
            default: begin
               state_reg <= WAIT_START;
            end
         endcase
      end
   end

endmodule
